// File: rtl/mem_port_arbiter_if.sv
// Bundle of the requester (I/D) and shared memory port signals seen by mem_port_arbiter.
// The slave modport is the arbiter's view; master is the core/memory environment's view.
interface mem_port_arbiter_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);
    logic              i_req;
    logic [AW-1:0]     i_adr;
    logic [DW-1:0]     i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_we;
    logic [AW-1:0]     d_adr;
    logic [DW-1:0]     d_wdata;
    logic [DW/8-1:0]   d_byteen;
    logic [DW-1:0]     d_rdata;
    logic              d_ack;

    logic              err;

    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_adr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_byteen;
    logic [DW-1:0]     mem_rdata;
    logic              mem_ack;

    modport slave (
        input  i_req, i_adr, d_req, d_we, d_adr, d_wdata, d_byteen, mem_rdata, mem_ack,
        output i_rdata, i_ack, d_rdata, d_ack, err,
               mem_req, mem_we, mem_adr, mem_wdata, mem_byteen
    );

    modport master (
        output i_req, i_adr, d_req, d_we, d_adr, d_wdata, d_byteen, mem_rdata, mem_ack,
        input  i_rdata, i_ack, d_rdata, d_ack, err,
               mem_req, mem_we, mem_adr, mem_wdata, mem_byteen
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the mips I-fetch and D requesters onto one shared memory port, with a
// round-robin tie-break and a watchdog that aborts unacknowledged transactions.
module mem_port_arbiter #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 32,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TW      = 8
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned BW = DW / 8;
    localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   wdog_q, wdog_d;
    logic            last_d_q, last_d_d;
    logic            win_d_q, win_d_d;

    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_adr_q, mem_adr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BW-1:0]   mem_byteen_q, mem_byteen_d;
    logic [DW-1:0]   i_rdata_q, i_rdata_d;
    logic [DW-1:0]   d_rdata_q, d_rdata_d;
    logic            i_ack_q, i_ack_d;
    logic            d_ack_q, d_ack_d;
    logic            err_q, err_d;

    logic            grant_d, grant_i;
    logic            timed_out, finish;

    // Next-state and next-output logic; acks and err default low so they pulse for one cycle.
    always_comb begin
        state_d      = state_q;
        wdog_d       = wdog_q;
        last_d_d     = last_d_q;
        win_d_d      = win_d_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_adr_d    = mem_adr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_byteen_d = mem_byteen_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        err_d        = 1'b0;
        grant_d      = 1'b0;
        grant_i      = 1'b0;
        timed_out    = 1'b0;
        finish       = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie, D wins unless D had the previous grant.
                grant_d = bus.d_req && (!bus.i_req || !last_d_q);
                grant_i = bus.i_req && !grant_d;
                if (grant_d || grant_i) begin
                    win_d_d   = grant_d;
                    last_d_d  = grant_d;
                    wdog_d    = '0;
                    mem_req_d = 1'b1;
                    state_d   = BUSY;
                    if (grant_d) begin
                        mem_we_d     = bus.d_we;
                        mem_adr_d    = bus.d_adr;
                        mem_wdata_d  = bus.d_wdata;
                        mem_byteen_d = bus.d_byteen;
                    end else begin
                        mem_we_d     = 1'b0;
                        mem_adr_d    = bus.i_adr;
                        mem_wdata_d  = '0;
                        mem_byteen_d = '1;
                    end
                end
            end
            BUSY: begin
                // A real ack takes priority over a watchdog expiry in the same cycle.
                timed_out = !bus.mem_ack && (wdog_q == WDOG_LAST);
                finish    = bus.mem_ack || timed_out;
                if (finish) begin
                    mem_req_d = 1'b0;
                    err_d     = timed_out;
                    state_d   = DONE;
                    if (win_d_q) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = timed_out ? '0 : bus.mem_rdata;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = timed_out ? '0 : bus.mem_rdata;
                    end
                end else begin
                    wdog_d = wdog_q + TW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            wdog_q       <= '0;
            last_d_q     <= 1'b0;
            win_d_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_adr_q    <= '0;
            mem_wdata_q  <= '0;
            mem_byteen_q <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wdog_q       <= wdog_d;
            last_d_q     <= last_d_d;
            win_d_q      <= win_d_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_adr_q    <= mem_adr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_byteen_q <= mem_byteen_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            err_q        <= err_d;
        end
    end

    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_adr    = mem_adr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_byteen = mem_byteen_q;
    assign bus.i_rdata    = i_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
    assign bus.i_ack      = i_ack_q;
    assign bus.d_ack      = d_ack_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes hand-computed expectations into
// queues; negedge monitors pop and compare whenever the arbiter presents an ack or a mem request.
module tb_mem_port_arbiter;
    localparam int NEVER = 100000;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dreq_t;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } ack_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          cyc;
        int          busy;
    } mem_exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    mem_port_arbiter_if #(.DW(32), .AW(32)) bus ();

    mem_port_arbiter #(.DW(32), .AW(32), .TIMEOUT(8), .TW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_pend = 1'b1;
    logic        rst_seen;
    logic        mon_en = 1'b0;
    logic [31:0] i_q[$];
    dreq_t       d_q[$];
    ack_exp_t    eq[$];
    mem_exp_t    mq[$];
    int          mem_wait = 0;
    int          mem_cnt = 0;
    logic        mem_inv = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic        stray = 1'b0;

    always @(posedge clk) rst_seen <= reset;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic exp_ack(input logic is_d, input logic [31:0] rdata, input logic err, input int c);
        eq.push_back('{is_d, rdata, err, c});
    endtask

    task automatic exp_mem(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                           input logic [3:0] be, input int c, input int busy);
        mq.push_back('{we, adr, wdata, be, c, busy});
    endtask

    task automatic push_d(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                          input logic [3:0] be);
        d_q.push_back('{we, adr, wdata, be});
    endtask

    // One cycle of requester and memory behaviour, applied at the negedge.
    task automatic step();
        @(negedge clk);
        reset = rst_pend;
        if (bus.i_ack && i_q.size() > 0) void'(i_q.pop_front());
        if (bus.d_ack && d_q.size() > 0) void'(d_q.pop_front());
        bus.i_req = (i_q.size() > 0);
        bus.i_adr = (i_q.size() > 0) ? i_q[0] : 32'h0;
        if (d_q.size() > 0) begin
            bus.d_req    = 1'b1;
            bus.d_we     = d_q[0].we;
            bus.d_adr    = d_q[0].adr;
            bus.d_wdata  = d_q[0].wdata;
            bus.d_byteen = d_q[0].be;
        end else begin
            bus.d_req    = 1'b0;
            bus.d_we     = 1'b0;
            bus.d_adr    = 32'h0;
            bus.d_wdata  = 32'h0;
            bus.d_byteen = 4'h0;
        end
        if (bus.mem_req) begin
            bus.mem_ack   = (mem_cnt == mem_wait);
            bus.mem_rdata = !bus.mem_ack ? 32'hBAD0_BAD0 : (mem_inv ? ~bus.mem_adr : mem_data);
            mem_cnt++;
        end else begin
            mem_cnt       = 0;
            bus.mem_ack   = stray;
            bus.mem_rdata = 32'hBAD0_BAD0;
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        i_q.delete();
        d_q.delete();
        rst_pend = 1'b1;
        step();
        rst_pend = 1'b0;
        step();
        chk("rst_mem", 128'({bus.mem_req, bus.mem_we, bus.mem_adr, bus.mem_wdata, bus.mem_byteen}), 128'(0));
        chk("rst_ack", 128'({bus.i_ack, bus.d_ack, bus.err}), 128'(0));
        chk("rst_rdata", 128'({bus.i_rdata, bus.d_rdata}), 128'(0));
    endtask

    // Ack scoreboard plus rdata hold model.
    ack_exp_t    ae;
    logic [31:0] i_last = 32'h0;
    logic [31:0] d_last = 32'h0;
    always @(negedge clk) begin
        if (rst_seen === 1'b1) begin
            i_last = 32'h0;
            d_last = 32'h0;
        end
        if (mon_en) begin
            if (bus.i_ack || bus.d_ack) begin
                if (eq.size() == 0) begin
                    chk("unexpected_ack", 128'({bus.i_ack, bus.d_ack}), 128'(0));
                end else begin
                    ae = eq.pop_front();
                    chk("ack_side", 128'({bus.i_ack, bus.d_ack}), ae.is_d ? 128'(1) : 128'(2));
                    chk("ack_cycle", 128'(cyc), 128'(ae.cyc));
                    chk("ack_err", 128'(bus.err), 128'(ae.err));
                    if (ae.is_d) d_last = ae.rdata;
                    else i_last = ae.rdata;
                end
            end else begin
                chk("err_outside_ack", 128'(bus.err), 128'(0));
            end
            chk("i_rdata", 128'(bus.i_rdata), 128'(i_last));
            chk("d_rdata", 128'(bus.d_rdata), 128'(d_last));
        end
    end

    // Shared-port scoreboard: start cycle, held fields, and request length.
    mem_exp_t mc;
    logic     m_act = 1'b0;
    int       m_cnt = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.mem_req) begin
                if (!m_act) begin
                    if (mq.size() == 0) begin
                        chk("unexpected_mem_req", 128'(bus.mem_req), 128'(0));
                    end else begin
                        mc = mq.pop_front();
                        m_act = 1'b1;
                        m_cnt = 0;
                        chk("mem_req_cycle", 128'(cyc), 128'(mc.cyc));
                    end
                end
                if (m_act) begin
                    chk("mem_fields",
                        128'({bus.mem_we, bus.mem_adr, bus.mem_wdata, bus.mem_byteen}),
                        128'({mc.we, mc.adr, mc.wdata, mc.be}));
                    m_cnt++;
                end
            end else if (m_act) begin
                m_act = 1'b0;
                chk("mem_req_len", 128'(m_cnt), 128'(mc.busy));
            end
        end
    end

    int b;
    int c;
    initial begin
        reset          = 1'b1;
        bus.i_req      = 1'b0;
        bus.i_adr      = 32'h0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_adr      = 32'h0;
        bus.d_wdata    = 32'h0;
        bus.d_byteen   = 4'h0;
        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 32'h0;
        step();
        do_reset();
        mon_en = 1'b1;

        // 1: D read, memory acks two cycles after mem_req rises
        mem_wait = 2; mem_inv = 1'b0; mem_data = 32'hDEAD_BEEF;
        push_d(1'b0, 32'h40, 32'h0, 4'hF);
        step(); b = cyc;
        exp_mem(1'b0, 32'h40, 32'h0, 4'hF, b + 1, 3);
        exp_ack(1'b1, 32'hDEAD_BEEF, 1'b0, b + 4);
        steps(7);

        // 2: both requesting after reset, zero-wait memory -> D, I, D, I
        do_reset();
        mem_wait = 0; mem_inv = 1'b1;
        push_d(1'b0, 32'h100, 32'h0, 4'hF);
        push_d(1'b0, 32'h104, 32'h0, 4'hF);
        i_q.push_back(32'h200);
        i_q.push_back(32'h204);
        step(); b = cyc;
        exp_mem(1'b0, 32'h100, 32'h0, 4'hF, b + 1, 1);
        exp_ack(1'b1, 32'hFFFF_FEFF, 1'b0, b + 2);
        exp_mem(1'b0, 32'h200, 32'h0, 4'hF, b + 4, 1);
        exp_ack(1'b0, 32'hFFFF_FDFF, 1'b0, b + 5);
        exp_mem(1'b0, 32'h104, 32'h0, 4'hF, b + 7, 1);
        exp_ack(1'b1, 32'hFFFF_FEFB, 1'b0, b + 8);
        exp_mem(1'b0, 32'h204, 32'h0, 4'hF, b + 10, 1);
        exp_ack(1'b0, 32'hFFFF_FDFB, 1'b0, b + 11);
        steps(14);

        // 3: D write with partial byte enables
        mem_wait = 1; mem_inv = 1'b0; mem_data = 32'h0000_5A5A;
        push_d(1'b1, 32'h80, 32'h1234_5678, 4'b0011);
        step(); b = cyc;
        exp_mem(1'b1, 32'h80, 32'h1234_5678, 4'b0011, b + 1, 2);
        exp_ack(1'b1, 32'h0000_5A5A, 1'b0, b + 3);
        steps(6);

        // 4: I request never acknowledged -> abort after 8 BUSY cycles, then D served
        mem_wait = NEVER;
        i_q.push_back(32'h300);
        step(); b = cyc;
        exp_mem(1'b0, 32'h300, 32'h0, 4'hF, b + 1, 8);
        exp_ack(1'b0, 32'h0, 1'b1, b + 9);
        steps(9);
        mem_wait = 0; mem_data = 32'h0BAD_F00D;
        push_d(1'b0, 32'h44, 32'h0, 4'hF);
        step(); c = cyc;
        chk("timeout_then_idle_cycle", 128'(c), 128'(b + 10));
        exp_mem(1'b0, 32'h44, 32'h0, 4'hF, c + 1, 1);
        exp_ack(1'b1, 32'h0BAD_F00D, 1'b0, c + 2);
        steps(5);

        // 5: reset on the second BUSY cycle of a D read, stray mem_ack, then tie goes to D
        mem_wait = NEVER;
        push_d(1'b0, 32'h60, 32'h0, 4'hF);
        step(); b = cyc;
        exp_mem(1'b0, 32'h60, 32'h0, 4'hF, b + 1, 2);
        step();
        rst_pend = 1'b1;
        d_q.delete();
        step();
        rst_pend = 1'b0;
        step();
        chk("reset_mid_mem_req", 128'(bus.mem_req), 128'(0));
        chk("reset_mid_d_ack", 128'(bus.d_ack), 128'(0));
        stray = 1'b1;
        step();
        stray = 1'b0;
        steps(3);
        mem_wait = 0; mem_inv = 1'b1;
        i_q.push_back(32'h500);
        push_d(1'b0, 32'h504, 32'h0, 4'hF);
        step(); c = cyc;
        exp_mem(1'b0, 32'h504, 32'h0, 4'hF, c + 1, 1);
        exp_ack(1'b1, 32'hFFFF_FAFB, 1'b0, c + 2);
        exp_mem(1'b0, 32'h500, 32'h0, 4'hF, c + 4, 1);
        exp_ack(1'b0, 32'hFFFF_FAFF, 1'b0, c + 5);
        steps(8);

        // 6: mem_ack lands on the watchdog's last cycle -> normal completion
        mem_wait = 7; mem_inv = 1'b0; mem_data = 32'hCAFE_F00D;
        i_q.push_back(32'h600);
        step(); b = cyc;
        exp_mem(1'b0, 32'h600, 32'h0, 4'hF, b + 1, 8);
        exp_ack(1'b0, 32'hCAFE_F00D, 1'b0, b + 9);
        steps(12);

        chk("acks_outstanding", 128'(eq.size()), 128'(0));
        chk("mem_reqs_outstanding", 128'(mq.size()), 128'(0));
        chk("mem_req_still_active", 128'(m_act), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
